seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands present on m/q.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port m  input  WIDTH  multiplicand.
REQ-007 SHALL have port q  input  WIDTH  multiplier.
REQ-008 SHALL have port out_valid  output  1  product on p is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port p  output  2*WIDTH  product.
REQ-011 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-013 SHALL accept operands on a rising edge with IDLE & in_valid, registering m and q and entering CALC; in_valid outside IDLE is ignored.
REQ-014 SHALL perform one shift-add step per CALC cycle: if multiplier LSB=1, add multiplicand to the upper WIDTH bits of the accumulator (WIDTH+1-bit sum, carry kept); then shift accumulator and multiplier right by one.
REQ-015 SHALL use an iteration counter of clog2(WIDTH) bits, cleared on accept, and SHALL leave CALC after exactly WIDTH steps.
REQ-016 SHALL have fixed latency: out_valid rises on the WIDTH-th rising edge after the accepting edge, independent of operand values (including zero operands).
REQ-017 SHALL load p on the CALC->DONE edge and hold p and out_valid stable while out_valid & !out_ready.
REQ-018 SHALL return to IDLE on the edge with DONE & out_ready; in_ready asserts the following cycle (no same-edge re-accept).
REQ-019 SHALL keep p at the last product after leaving DONE until the next CALC->DONE edge.
REQ-020 SHALL produce p = m*q exactly (unsigned, no truncation) for all operand pairs.

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, counter 0, accumulator 0, p=0, out_valid=0, busy=0, and in_ready=1 after release.
REQ-022 SHALL abort any CALC or DONE transaction on reset assertion; the in-flight product is discarded and never presented.
REQ-023 SHALL require rst_n deassertion synchronised externally; no internal synchroniser.

Configuration
REQ-024 SHALL, with macro SEQ_MULT_SIGNED_EN defined, add input port sgn (1 bit, sampled with operands); sgn=1 treats m, q as two's complement and p as signed 2*WIDTH result; sgn=0 is unsigned.
REQ-025 SHALL, for signed mode, multiply operand magnitudes and negate the result on the CALC->DONE edge when signs differ, adding no latency; -2^(WIDTH-1) operands SHALL be handled via WIDTH-bit unsigned magnitude.
REQ-026 SHALL, without SEQ_MULT_SIGNED_EN, omit port sgn and all sign logic; behaviour is unsigned only.

Structure
REQ-027 SHALL place the state enumeration (IDLE, CALC, DONE) and default WIDTH constant in shared package seq_mult_pkg.
REQ-028 SHALL instantiate one sub-module rca_add: WIDTH-parameterised ripple-carry adder built from per-bit full adders, outputs sum and carry-out.
REQ-029 SHALL contain no combinational path from in_valid/out_ready to in_ready/out_valid.

Verification
REQ-030 SHALL verify WIDTH=8: m=0xFF, q=0xFF accepted -> out_valid rises 8 edges later, p=0xFE01.
REQ-031 SHALL verify backpressure: m=0x12, q=0x34, out_ready=0 for 5 cycles -> p=0x03A8 and out_valid held stable; release -> IDLE next edge, in_ready=1 one cycle later.
REQ-032 SHALL verify reset mid-CALC: accept 0x0F*0x0F, drop rst_n at step 3 -> p=0, out_valid=0, no product emerges after release.
REQ-033 SHALL verify in_valid during busy: second operand pair held high in CALC -> ignored; only first product emitted; second accepted after return to IDLE.
REQ-034 SHALL verify with SEQ_MULT_SIGNED_EN, WIDTH=8, sgn=1: 0x80*0x80 -> p=0x4000; 0xFF*0x01 -> p=0xFFFF; sgn=0: 0xFF*0x01 -> p=0x00FF.
REQ-035 SHALL verify WIDTH=4 exhaustively: all 256 pairs, random out_ready -> p matches m*q, each latency exactly 4.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_rca_add.sv
// rca_add: WIDTH-bit ripple-carry adder built from per-bit full adders.
module rca_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic w_x;
    assign w_x        = i_a[i] ^ i_b[i];
    assign o_sum[i]   = w_x ^ w_c[i];
    assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & w_x);
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// seq_mult: unsigned shift-add multiplier, one step per cycle, WIDTH-cycle latency.
// Define SEQ_MULT_SIGNED_EN to add the sgn port for two's-complement operands.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out bit by bit as the product fills in from the top.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_m_ld;
  logic [WIDTH-1:0]   w_q_ld;
  logic               w_last;

  assign w_addend  = r_acc[0] ? r_m : '0;
  assign w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  rca_add #(.WIDTH(WIDTH)) u_add (
    .i_a    (r_acc[2*WIDTH-1:WIDTH]),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [WIDTH-1:0]   M_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic r_neg;
  logic w_m_neg;
  logic w_q_neg;

  // Magnitudes fit WIDTH unsigned bits, so the most negative value maps cleanly.
  assign w_m_neg = sgn & m[WIDTH-1];
  assign w_q_neg = sgn & q[WIDTH-1];
  assign w_m_ld  = w_m_neg ? (~m + M_ONE) : m;
  assign w_q_ld  = w_q_neg ? (~q + M_ONE) : q;
  assign w_prod  = r_neg ? (~w_acc_nxt + P_ONE) : w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_neg <= 1'b0;
    else if (r_state == IDLE && in_valid)
      r_neg <= w_m_neg ^ w_q_neg;
  end
`else
  assign w_m_ld = m;
  assign w_q_ld = q;
  assign w_prod = w_acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m        <= w_m_ld;
            r_acc      <= {{WIDTH{1'b0}}, w_q_ld};
            r_cnt      <= '0;
            r_state    <= CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= DONE;
            r_p         <= w_prod;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign p         = r_p;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: WIDTH=8 vectors/random/corner sequences, WIDTH=4 exhaustive.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;
  logic        iv4, ir4, ov4, or4, busy4;
  logic [3:0]  m4, q4;
  logic [7:0]  p4;
`ifdef SEQ_MULT_SIGNED_EN
  logic        s8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .m(m8), .q(q8),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn(s8),
`endif
    .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
  );

  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .m(m4), .q(q4),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn(1'b0),
`endif
    .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
  );

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic        s;
    logic [15:0] exp_p;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer product of the operand values as interpreted.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y, r;
    x = (s && a[7]) ? int'(a) - 256 : int'(a);
    y = (s && b[7]) ? int'(b) - 256 : int'(b);
    r = x * y;
    return r[15:0];
  endfunction

  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input int stall, output logic [15:0] got);
    int t, lat;
    @(negedge clk);
    t = 0;
    while (!ir8 && t < 100) begin @(negedge clk); t++; end
    chk("in_ready_before_accept", ir8, 1);
    m8 = a; q8 = b; iv8 = 1'b1; or8 = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    s8 = s;
`endif
    @(posedge clk); #1 iv8 = 1'b0;
    chk("busy_after_accept", {busy8, ir8}, 2'b10);
    lat = 0;
    while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("latency8", lat, 8);
    got = p8;
    chk("p8", got, ref8(a, b, s));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold8", {ov8, busy8, p8}, {2'b11, got});
    end
    @(negedge clk) or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    chk("release8", {ov8, ir8, busy8}, 3'b010);
  endtask

  initial begin
    vec_t tbl[$];
    logic [15:0] got;
    logic [15:0] prods[2];
    logic [7:0] e4;
    int np, cyc, t, lat, k;
    logic seen, done, r;

    iv8 = 0; or8 = 0; m8 = 0; q8 = 0;
    iv4 = 0; or4 = 0; m4 = 0; q4 = 0;
`ifdef SEQ_MULT_SIGNED_EN
    s8 = 0;
`endif

    tbl.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
    tbl.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 16'h0000});
    tbl.push_back('{8'h00, 8'hFF, 1'b0, 16'h0000});
    tbl.push_back('{8'h01, 8'h01, 1'b0, 16'h0001});
    tbl.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF});
    tbl.push_back('{8'h0F, 8'h0F, 1'b0, 16'h00E1});
`ifdef SEQ_MULT_SIGNED_EN
    tbl.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
    tbl.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
    tbl.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
    tbl.push_back('{8'h05, 8'hFD, 1'b1, 16'hFFF1});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs8", {p8, ov8, busy8}, 18'h0);
    chk("reset_outputs4", {p4, ov4, busy4}, 10'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("in_ready_after_reset", {ir8, ir4}, 2'b11);

    // Table vectors; 0x12*0x34 gets a 5-cycle stall
    foreach (tbl[i]) begin
      do8(tbl[i].m, tbl[i].q, tbl[i].s, (tbl[i].m == 8'h12) ? 5 : i % 3, got);
      chk("table_p8", got, tbl[i].exp_p);
    end

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
`ifdef SEQ_MULT_SIGNED_EN
      r = 1'($urandom_range(0, 1));
`else
      r = 1'b0;
`endif
      do8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), r, $urandom_range(0, 2), got);
    end

    // Reset in the middle of CALC discards the product
    @(negedge clk);
    m8 = 8'h0F; q8 = 8'h0F; iv8 = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    s8 = 1'b0;
`endif
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midcalc_reset", {p8, ov8, busy8}, 18'h0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov8 || busy8 || p8 != 16'h0) seen = 1'b1;
    end
    chk("no_product_after_reset", seen, 1'b0);
    chk("idle_after_reset", ir8, 1'b1);

    // in_valid held through CALC/DONE: second pair waits for IDLE
    @(negedge clk);
    m8 = 8'd3; q8 = 8'd5; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1 m8 = 8'd7; q8 = 8'd9;
    np = 0; cyc = 0;
    while (np < 2 && cyc < 60) begin
      @(posedge clk); #1 cyc++;
      if (ov8) begin prods[np] = p8; np++; end
    end
    iv8 = 1'b0; or8 = 1'b0;
    chk("busy_ignore_count", np, 2);
    chk("busy_ignore_first", prods[0], 16'd15);
    chk("busy_ignore_second", prods[1], 16'd63);
    chk("second_accept_timing", cyc, 18);
    @(posedge clk); #1;

    // WIDTH=4 exhaustive with random out_ready
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        t = 0;
        while (!ir4 && t < 50) begin @(negedge clk); t++; end
        chk("in_ready4", ir4, 1'b1);
        m4 = 4'(a); q4 = 4'(b); iv4 = 1'b1; or4 = 1'b0;
        @(posedge clk); #1 iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 50) begin @(posedge clk); #1; lat++; end
        e4 = 8'(a * b);
        chk("latency4", lat, 4);
        chk("p4", p4, e4);
        done = 1'b0; k = 0;
        while (!done && k < 20) begin
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          or4 = r;
          @(posedge clk); #1;
          if (r) done = 1'b1;
          else chk("hold4", {ov4, p4}, {1'b1, e4});
          k++;
        end
        or4 = 1'b0;
        chk("release4", {ov4, done}, 2'b01);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
